// File: rtl/gg_order_pkg.sv
// Shared order-path types: order request record, side encoding and default field widths.
package gg_order_pkg;

  localparam int SEQ_W_DEF = 32;
  localparam int LAT_W_DEF = 16;
  localparam int IDX_W_DEF = 3;

  typedef enum logic {
    BUY  = 1'b0,
    SELL = 1'b1
  } side_t;

  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic [63:0]          price;
    logic [31:0]          qty;
    side_t                side;
    logic [SEQ_W_DEF-1:0] seq;
    logic [LAT_W_DEF-1:0] latency;
  } order_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, found by scanning
// a doubled request vector masked below ptr.
module rr_arbiter
  import gg_order_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [2*N-1:0] mask_s;
  logic [2*N-1:0] masked_s;
  logic           hit_s;

  // Lowest set bit of the masked double-width vector, folded back modulo N.
  always_comb begin
    mask_s   = {(2*N){1'b1}} << ptr;
    masked_s = {req, req} & mask_s;
    hit_s    = 1'b0;
    gnt_idx  = '0;
    for (int k = 0; k < 2*N; k++) begin
      if (masked_s[k] && !hit_s) begin
        hit_s   = 1'b1;
        gnt_idx = IDX_W'(k % N);
      end else begin
        hit_s = hit_s;
      end
    end
    if (hit_s) begin
      gnt_onehot = N'(1) << gnt_idx;
    end else begin
      gnt_onehot = '0;
    end
    any = hit_s;
  end

endmodule

// File: rtl/fire_dispatcher.sv
// One-shot per-instrument order dispatcher: edge-detects fire, arbitrates pending lanes
// round-robin and presents template-built orders on a valid/ready interface.
module fire_dispatcher
  import gg_order_pkg::*;
#(
  parameter int MAX_INSTRUMENTS = 8,
  parameter int IDX_W           = $clog2(MAX_INSTRUMENTS),
  parameter int SEQ_W           = SEQ_W_DEF,
  parameter int LAT_W           = LAT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MAX_INSTRUMENTS-1:0] fire,
  input  logic [MAX_INSTRUMENTS-1:0] enable,
  input  logic [MAX_INSTRUMENTS-1:0] rearm,
  input  logic [63:0]                price_tmpl [MAX_INSTRUMENTS],
  input  logic [31:0]                qty_tmpl   [MAX_INSTRUMENTS],
  input  logic [MAX_INSTRUMENTS-1:0] side_tmpl,
  output logic                       order_valid,
  input  logic                       order_ready,
  output logic [IDX_W-1:0]           order_idx,
  output logic [63:0]                order_price,
  output logic [31:0]                order_qty,
  output logic                       order_side,
  output logic [SEQ_W-1:0]           order_seq,
  output logic [LAT_W-1:0]           order_latency,
  output logic [MAX_INSTRUMENTS-1:0] sent,
  output logic [MAX_INSTRUMENTS-1:0] pending_o
);

  localparam int N = MAX_INSTRUMENTS;

  logic [N-1:0]     fire_q_r;
  logic [N-1:0]     pending_r;
  logic [LAT_W-1:0] lat_r [N];
  logic [IDX_W-1:0] ptr_r;
  logic [SEQ_W-1:0] seq_r;

  logic [N-1:0]     rise_s;
  logic [N-1:0]     set_s;
  logic             accept_s;
  logic             slot_free_s;
  logic             grant_s;
  logic [SEQ_W-1:0] seq_next_s;
  logic [N-1:0]     gnt_onehot_s;
  logic [IDX_W-1:0] gnt_idx_s;
  logic             any_s;

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
    .req        (pending_r),
    .ptr        (ptr_r),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .any        (any_s)
  );

  // Rearm suppresses a coincident rise; a back-to-back grant takes the post-accept sequence.
  always_comb begin
    rise_s      = fire & ~fire_q_r;
    set_s       = rise_s & enable & ~sent & ~pending_r & ~rearm;
    accept_s    = order_valid & order_ready;
    slot_free_s = ~order_valid | order_ready;
    grant_s     = any_s & slot_free_s;
    seq_next_s  = accept_s ? (seq_r + SEQ_W'(1)) : seq_r;
  end

  // Per-lane state: fire history, pending, sent and saturating latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_q_r  <= '0;
      pending_r <= '0;
      sent      <= '0;
      for (int i = 0; i < N; i++) lat_r[i] <= '0;
    end else begin
      fire_q_r <= fire;
      for (int i = 0; i < N; i++) begin
        if (rearm[i]) begin
          pending_r[i] <= 1'b0;
          lat_r[i]     <= '0;
        end else if (set_s[i]) begin
          pending_r[i] <= 1'b1;
          lat_r[i]     <= '0;
        end else begin
          if (grant_s && gnt_onehot_s[i]) pending_r[i] <= 1'b0;
          if (pending_r[i] && (lat_r[i] != {LAT_W{1'b1}})) lat_r[i] <= lat_r[i] + LAT_W'(1);
        end
        if (rearm[i]) begin
          sent[i] <= 1'b0;
        end else if (accept_s && (order_idx == IDX_W'(i))) begin
          sent[i] <= 1'b1;
        end
      end
    end
  end

  // Output slot, sequence counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      order_valid   <= 1'b0;
      order_idx     <= '0;
      order_price   <= '0;
      order_qty     <= '0;
      order_side    <= 1'b0;
      order_seq     <= '0;
      order_latency <= '0;
      ptr_r         <= '0;
      seq_r         <= '0;
    end else begin
      seq_r <= seq_next_s;
      if (grant_s) begin
        order_valid   <= 1'b1;
        order_idx     <= gnt_idx_s;
        order_price   <= price_tmpl[gnt_idx_s];
        order_qty     <= qty_tmpl[gnt_idx_s];
        order_side    <= side_tmpl[gnt_idx_s];
        order_seq     <= seq_next_s;
        order_latency <= lat_r[gnt_idx_s];
        ptr_r         <= (gnt_idx_s == IDX_W'(N-1)) ? '0 : gnt_idx_s + IDX_W'(1);
      end else if (accept_s) begin
        order_valid <= 1'b0;
      end
    end
  end

  assign pending_o = pending_r;

endmodule

// File: tb/tb_fire_dispatcher.sv
// Scoreboard bench for fire_dispatcher: directed fire patterns push expected orders,
// a negedge monitor pops and compares every accepted order.
module tb_fire_dispatcher;
  import gg_order_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] fire, enable, rearm, side_tmpl;
  logic [63:0]  price_tmpl [N];
  logic [31:0]  qty_tmpl [N];
  logic         order_valid, order_ready, order_side;
  logic [2:0]   order_idx;
  logic [63:0]  order_price;
  logic [31:0]  order_qty;
  logic [31:0]  order_seq;
  logic [15:0]  order_latency;
  logic [N-1:0] sent, pending_o;

  int checks = 0;
  int errors = 0;
  order_req_t exp_q[$];
  order_req_t mon_act, mon_exp;

  always #5 clk = ~clk;

  fire_dispatcher dut (
    .clk(clk), .rst(rst), .fire(fire), .enable(enable), .rearm(rearm),
    .price_tmpl(price_tmpl), .qty_tmpl(qty_tmpl), .side_tmpl(side_tmpl),
    .order_valid(order_valid), .order_ready(order_ready), .order_idx(order_idx),
    .order_price(order_price), .order_qty(order_qty), .order_side(order_side),
    .order_seq(order_seq), .order_latency(order_latency), .sent(sent), .pending_o(pending_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] base_price(input int idx);
    return 64'h0123_4567_0000_0000 + 64'(idx);
  endfunction

  function automatic order_req_t mk(input int idx, input logic [63:0] price, input int seq, input int lat);
    order_req_t r;
    r.idx     = 3'(idx);
    r.price   = price;
    r.qty     = 32'd100 + 32'(idx);
    r.side    = side_t'(idx % 2);
    r.seq     = 32'(seq);
    r.latency = 16'(lat);
    return r;
  endfunction

  // Monitor: every accepted order must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && order_valid && order_ready) begin
      mon_act.idx     = order_idx;
      mon_act.price   = order_price;
      mon_act.qty     = order_qty;
      mon_act.side    = side_t'(order_side);
      mon_act.seq     = order_seq;
      mon_act.latency = order_latency;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_order actual idx=%0d seq=%0d expected none", order_idx, order_seq);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL order actual=%h expected=%h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    fire        = '0;
    enable      = '1;
    rearm       = '0;
    order_ready = 1'b1;
    rst         = 1'b0;
    for (int i = 0; i < N; i++) begin
      price_tmpl[i] = base_price(i);
      qty_tmpl[i]   = 32'd100 + 32'(i);
      side_tmpl[i]  = i[0];
    end
    #1 rst = 1'b1;
    tick(2);
    check("rst_valid", 64'(order_valid), 64'd0);
    check("rst_seq", 64'(order_seq), 64'd0);
    check("rst_price", order_price, 64'd0);
    check("rst_sent", 64'(sent), 64'd0);
    check("rst_pending", 64'(pending_o), 64'd0);
    rst = 1'b0;
    tick(3);

    // Single fire on lane 3, then held high with no second order.
    exp_q.push_back(mk(3, base_price(3), 0, 0));
    fire[3] = 1'b1;
    tick(1);
    check("s1_pending", 64'(pending_o), 64'h08);
    tick(1);
    check("s1_valid", 64'(order_valid), 64'd1);
    tick(1);
    check("s1_sent", 64'(sent), 64'h08);
    tick(20);
    check("s1_no_repeat_valid", 64'(order_valid), 64'd0);
    check("s1_sent_hold", 64'(sent), 64'h08);

    // Fresh start, then simultaneous fires on lanes 1,5,6; pointer then sits at 7.
    fire = '0;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    exp_q.push_back(mk(1, base_price(1), 0, 0));
    exp_q.push_back(mk(5, base_price(5), 1, 1));
    exp_q.push_back(mk(6, base_price(6), 2, 2));
    fire = 8'b0110_0010;
    tick(5);
    check("s2_sent", 64'(sent), 64'h62);
    exp_q.push_back(mk(7, base_price(7), 3, 0));
    exp_q.push_back(mk(0, base_price(0), 4, 1));
    fire = fire | 8'h81;
    tick(5);
    check("s2_ptr_sent", 64'(sent), 64'hE3);

    // Backpressure on lane 2 with a template change and a lane 4 fire during the stall.
    order_ready = 1'b0;
    fire[2] = 1'b1;
    exp_q.push_back(mk(2, base_price(2), 5, 0));
    tick(2);
    check("s3_valid", 64'(order_valid), 64'd1);
    check("s3_idx", 64'(order_idx), 64'd2);
    price_tmpl[2] = 64'hDEAD_BEEF_0000_0002;
    fire[4] = 1'b1;
    exp_q.push_back(mk(4, base_price(4), 6, 5));
    for (int c = 0; c < 6; c++) begin
      tick(1);
      check("s3_hold_price", order_price, base_price(2));
      check("s3_hold_seq", 64'(order_seq), 64'd5);
    end
    order_ready = 1'b1;
    tick(3);
    check("s3_sent", 64'(sent), 64'hF7);

    // Rearm lane 0 and re-fire; then rearm coincident with a rise.
    rearm[0] = 1'b1;
    fire[0]  = 1'b0;
    tick(1);
    rearm[0] = 1'b0;
    check("s4_rearm_sent", 64'(sent), 64'hF6);
    tick(1);
    exp_q.push_back(mk(0, base_price(0), 7, 0));
    fire[0] = 1'b1;
    tick(4);
    check("s4_resent", 64'(sent), 64'hF7);
    fire[0] = 1'b0;
    tick(1);
    fire[0]  = 1'b1;
    rearm[0] = 1'b1;
    tick(1);
    rearm[0] = 1'b0;
    check("s4_coinc_pending", 64'(pending_o), 64'd0);
    tick(5);
    check("s4_coinc_sent", 64'(sent), 64'hF6);

    // Disabled lane 7 ignores its rise; enabling later without a new edge does nothing.
    rearm[7] = 1'b1;
    fire[7]  = 1'b0;
    tick(1);
    rearm[7]  = 1'b0;
    enable[7] = 1'b0;
    tick(1);
    fire[7] = 1'b1;
    tick(3);
    check("s5_dis_pending", 64'(pending_o), 64'd0);
    enable[7] = 1'b1;
    tick(5);
    check("s5_en_pending", 64'(pending_o), 64'd0);
    check("s5_sent", 64'(sent), 64'h76);

    // Asynchronous reset while an order is stalled on the output.
    order_ready = 1'b0;
    fire[3] = 1'b1;
    tick(2);
    check("s6_valid", 64'(order_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("s6_rst_valid", 64'(order_valid), 64'd0);
    check("s6_rst_idx", 64'(order_idx), 64'd0);
    check("s6_rst_price", order_price, 64'd0);
    check("s6_rst_lat", 64'(order_latency), 64'd0);
    check("s6_rst_sent", 64'(sent), 64'd0);
    fire = '0;
    tick(1);
    rst = 1'b0;
    tick(1);
    order_ready = 1'b1;
    exp_q.push_back(mk(2, 64'hDEAD_BEEF_0000_0002, 0, 0));
    fire[2] = 1'b1;
    tick(4);
    check("s6_sent", 64'(sent), 64'h04);

    for (int w = 0; w < 50 && exp_q.size() != 0; w++) tick(1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fire_dispatcher.md
Name: fire_dispatcher

Overview:
Sits directly downstream of the per-instrument trigger stage and consumes its `fire` vector. Each instrument is one-shot: a rising edge on `fire[i]` makes that instrument pending, and each pending instrument produces exactly one order request. Pending instruments are served by round-robin arbitration. Each order is built from per-instrument templates and presented on a valid/ready interface to the order-entry encoder, with a sequence number and the trigger-to-grant latency attached.

Parameters:
MAX_INSTRUMENTS, 8, number of trigger lanes; must match the upstream trigger stage.
IDX_W, $clog2(MAX_INSTRUMENTS), width of the instrument index.
SEQ_W, 32, width of the order sequence number.
LAT_W, 16, width of the latency field; the latency counter saturates at its maximum.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
fire  in  MAX_INSTRUMENTS  per-instrument fire level from the trigger stage
enable  in  MAX_INSTRUMENTS  per-instrument dispatch enable; a rising edge while disabled is ignored
rearm  in  MAX_INSTRUMENTS  single-cycle pulse; clears sent and pending for that lane
price_tmpl  in  64 x MAX_INSTRUMENTS  unpacked array; limit price per instrument
qty_tmpl  in  32 x MAX_INSTRUMENTS  unpacked array; order quantity per instrument
side_tmpl  in  1 x MAX_INSTRUMENTS  order side, 0 = buy, 1 = sell
order_valid  out  1  order request valid
order_ready  in  1  downstream accept
order_idx  out  IDX_W  instrument index
order_price  out  64  captured price_tmpl
order_qty  out  32  captured qty_tmpl
order_side  out  1  captured side_tmpl
order_seq  out  SEQ_W  sequence number; starts at 0, +1 per accepted order
order_latency  out  LAT_W  cycles from the fire edge to the grant
sent  out  MAX_INSTRUMENTS  lanes whose order has been accepted
pending_o  out  MAX_INSTRUMENTS  lanes awaiting grant (debug)

Behaviour:
- Reset values (rst = 1, asynchronous):
  - all outputs = 0;
  - the fire_q history register = 0;
  - the round-robin pointer = 0;
  - the sequence counter = 0;
  - all lane latency counters = 0.
- Edge detect: `rise[i] = fire[i] & ~fire_q[i]`; `fire_q` is registered every cycle. A level held high generates one rise only.
- Pending set: `pending[i]` sets on `rise[i] & enable[i] & ~sent[i] & ~pending[i]`. At the same time the lane latency counter `lat[i]` loads 0.
- Latency count: while `pending[i]` is set, `lat[i]` increments by 1 per cycle and saturates at 2^LAT_W-1.
- Rearm: `rearm[i]` clears `pending[i]`, `sent[i]` and `lat[i]`.
  - Rearm wins over a rise in the same cycle; that rise is lost.
  - An order for lane i already presented on the output is not withdrawn.
- Arbiter states:
  - IDLE: `order_valid` = 0.
  - Grant when `pending != 0` and the output slot is free. The slot is free when `order_valid` = 0, or when `order_valid & order_ready` in this cycle.
  - Pick the first pending lane at or after the RR pointer, wrapping modulo MAX_INSTRUMENTS.
- On grant to lane g:
  - capture `price_tmpl[g]`, `qty_tmpl[g]`, `side_tmpl[g]`, `lat[g]` and the current sequence counter into the output registers;
  - set `order_valid` = 1 on the next edge;
  - clear `pending[g]`;
  - set the RR pointer to (g+1) mod MAX_INSTRUMENTS.
- Latency: one clock from a pending set to `order_valid`, when the output is idle. `order_latency` reports the grant cycle count; a rise followed by an immediate grant reports 0.
- HOLD: while `order_valid & ~order_ready`, all `order_*` outputs stay stable and no new grant occurs.
- Accept (`order_valid & order_ready`):
  - set `sent[order_idx]`;
  - increment the sequence counter, wrapping at 2^SEQ_W;
  - issue a back-to-back grant in the same cycle if anything is pending, otherwise drop `order_valid` to 0.
- Throughput: one order per cycle under continuous `order_ready`.
- Template sampling: templates are sampled at grant only; later changes do not affect an order already presented.
- Reset mid-operation: asynchronous clear of everything. An order on the output is dropped; downstream must tolerate `order_valid` falling without acceptance during reset.
- Enable: deasserting `enable[i]` while the lane is pending does not cancel it. Enable gates only the set.

Decomposition:
- Shared package `gg_order_pkg`:
  - `order_req_t` packed struct (idx, price, qty, side, seq, latency);
  - `side_t` enum (BUY = 0, SELL = 1);
  - SEQ_W/LAT_W default constants.
- One sub-module, `rr_arbiter` (parameter N): inputs `req`, `ptr`; outputs `gnt_onehot`, `gnt_idx`, `any`. Purely combinational, implemented as a double-width priority mask.

Test Plan:
- Single fire: lane 3 enabled, fire[3] rises at cycle 10, order_ready = 1 → at cycle 11 order_valid = 1, idx = 3, price = price_tmpl[3], seq = 0, latency = 0; at cycle 12 sent[3] = 1. Holding fire[3] high for 20 cycles → no second order.
- Simultaneous fires: lanes 1, 5, 6 rise together, RR pointer = 0, ready = 1 → orders on consecutive cycles with idx 1, 5, 6 and seq 0, 1, 2; pointer ends at 7.
- Backpressure: lane 2 fires, ready = 0 for 5 cycles, price_tmpl[2] changed during the stall → outputs stable throughout and carry the original price; lane 4 firing during the stall is granted after the accept with latency = 5 or more.
- Rearm: lane 0 sent, rearm[0] pulse, fire[0] toggles low then high → a second order for lane 0 with seq incremented. Rearm coincident with a rise → no order.
- Enable: enable[7] = 0 while fire[7] rises → no order and pending_o[7] = 0; enable[7] = 1 later with fire still high → still no order (no new edge).
- Reset mid-operation: rst asserted while order_valid = 1 and ready = 0 → all outputs 0 immediately (asynchronous). After release, the seq of the next order is 0.
